// File: rtl/systemizer_host_ctrl.sv
// Host controller for the systemizer load/start/readback interface.
// Streams matrix words from a valid/ready source into systemizer memory, issues start,
// performs the right-part reload on left success, then streams the result memory out.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   go                           job start pulse (sampled in idle only)
//   in_data/in_valid/in_ready    source word stream; src_rewind restarts the source
//   out_data/out_valid/out_ready result word stream
//   busy, job_done, job_fail     job status; cycle_count = compute cycles of last job
//   sys_*                        systemizer control, status and memory ports
module systemizer_host_ctrl #(
  parameter int unsigned N = 4,
  parameter int unsigned L = 8,
  parameter int unsigned K = 16,
  parameter int unsigned M = 16,
  localparam int unsigned SW = $clog2(M),
  localparam int unsigned DW = N * SW,
  localparam int unsigned WT = L * K / N,
  localparam int unsigned WS = L * L / N,
  localparam int unsigned AW = $clog2(WT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          src_rewind,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          job_done,
  output logic          job_fail,
  output logic [31:0]   cycle_count,
  input  logic [1:0]    sys_gen_left_op,
  input  logic [1:0]    sys_gen_right_op,
  output logic          sys_start,
  output logic          sys_start_right,
  input  logic          sys_done,
  input  logic          sys_success,
  input  logic          sys_fail,
  output logic          sys_wr_en,
  output logic [AW-1:0] sys_wr_addr,
  output logic [DW-1:0] sys_wr_data,
  output logic          sys_rd_en,
  output logic [AW-1:0] sys_rd_addr,
  input  logic [DW-1:0] sys_rd_data
);

  localparam logic [AW:0] WtW   = (AW+1)'(WT);
  localparam logic [AW:0] WsW   = (AW+1)'(WS);
  localparam logic [AW:0] LastW = (AW+1)'(WT - 1);
  localparam logic [AW:0] OneW  = (AW+1)'(1);

  typedef enum logic [3:0] {
    StIdle, StLoadL, StStartL, StWaitL, StRewind, StLoadR,
    StStartR, StWaitR, StRead, StFinOk, StFinFail
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic            right_q;
  logic [AW:0]     idx_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [31:0]     cnt_q;
  logic            counting_q;
  logic [AW:0]     rd_ptr_q;
  logic [AW:0]     pop_cnt_q;
  logic            rd_inflight_q;
  logic [DW-1:0]   buf_q [2];
  logic            buf_wp_q, buf_rp_q;
  logic [1:0]      occ_q;

  logic [AW:0]     load_low, load_end;
  logic            accept, pop, push, success_take, terminal;

  // Source words with index below load_low are consumed but not written.
  always_comb begin
    load_low = '0;
    load_end = WtW;
    if (!right_q) begin
      if (op_q == 2'b01) load_end = WsW;
    end else begin
      case (op_q)
        2'b01:   load_end = WsW;
        2'b10:   load_low = WsW;
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == StLoadL || state_q == StLoadR) && (idx_q < load_end);
  assign accept       = in_ready && in_valid;
  assign out_valid    = (occ_q != 2'd0);
  assign out_data     = buf_q[buf_rp_q];
  assign pop          = out_valid && out_ready;
  assign push         = rd_inflight_q;
  // Issue a read only when the buffer can absorb it alongside any read in flight.
  assign sys_rd_en    = (state_q == StRead) && (rd_ptr_q < WtW) &&
                        (({1'b0, occ_q} + {2'b00, rd_inflight_q}) < 3'd2);
  assign sys_rd_addr  = sys_rd_en ? rd_ptr_q[AW-1:0] : '0;
  assign sys_wr_en    = wr_en_q;
  assign sys_wr_addr  = wr_addr_q;
  assign sys_wr_data  = wr_data_q;
  assign cycle_count  = cnt_q;
  assign success_take = (state_q == StWaitL) && sys_success && !sys_fail && !sys_done;
  assign terminal     = (state_q == StWaitL || state_q == StWaitR) && (sys_fail || sys_done);

  always_comb begin
    state_d         = state_q;
    busy            = (state_q != StIdle);
    src_rewind      = 1'b0;
    sys_start       = 1'b0;
    sys_start_right = 1'b0;
    job_done        = 1'b0;
    job_fail        = 1'b0;
    unique case (state_q)
      StIdle:   if (go) state_d = StRewind;
      StRewind: begin
        src_rewind = 1'b1;
        state_d    = right_q ? StLoadR : StLoadL;
      end
      StLoadL:  if (idx_q == load_end) state_d = StStartL;
      StStartL: begin
        sys_start = 1'b1;
        state_d   = StWaitL;
      end
      StWaitL: begin
        if (sys_fail)         state_d = StFinFail;
        else if (sys_done)    state_d = StRead;
        else if (sys_success) state_d = StRewind;
      end
      StLoadR:  if (idx_q == load_end) state_d = StStartR;
      StStartR: begin
        sys_start_right = 1'b1;
        state_d         = StWaitR;
      end
      StWaitR: begin
        if (sys_fail)      state_d = StFinFail;
        else if (sys_done) state_d = StRead;
      end
      StRead:   if (pop && pop_cnt_q == LastW) state_d = StFinOk;
      StFinOk: begin
        job_done = 1'b1;
        state_d  = StIdle;
      end
      StFinFail: begin
        job_fail = 1'b1;
        state_d  = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      right_q    <= 1'b0;
      idx_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cnt_q      <= '0;
      counting_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && go)    op_q <= sys_gen_left_op;
      else if (success_take)          op_q <= sys_gen_right_op;
      if (state_q == StIdle)          right_q <= 1'b0;
      else if (success_take)          right_q <= 1'b1;
      if (state_q == StRewind)        idx_q <= '0;
      else if (accept)                idx_q <= idx_q + OneW;
      wr_en_q <= accept && (idx_q >= load_low);
      if (accept) begin
        wr_addr_q <= idx_q[AW-1:0];
        wr_data_q <= in_data;
      end
      // Count runs from the start pulse through the cycle that shows terminal status.
      if (state_q == StStartL) begin
        cnt_q      <= '0;
        counting_q <= 1'b1;
      end else if (counting_q) begin
        cnt_q <= cnt_q + 32'd1;
        if (terminal) counting_q <= 1'b0;
      end
    end
  end

  // Readback path: read pointer, in-flight flag and 2-entry skid buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q      <= '0;
      pop_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      buf_wp_q      <= 1'b0;
      buf_rp_q      <= 1'b0;
      occ_q         <= 2'd0;
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
    end else if (state_q == StIdle) begin
      rd_ptr_q      <= '0;
      pop_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      buf_wp_q      <= 1'b0;
      buf_rp_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      rd_inflight_q <= sys_rd_en;
      if (sys_rd_en) rd_ptr_q <= rd_ptr_q + OneW;
      if (push) begin
        buf_q[buf_wp_q] <= sys_rd_data;
        buf_wp_q        <= ~buf_wp_q;
      end
      if (pop) begin
        buf_rp_q  <= ~buf_rp_q;
        pop_cnt_q <= pop_cnt_q + OneW;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_systemizer_host_ctrl.sv
module tb_systemizer_host_ctrl;
  localparam int AW = 5;
  localparam int DW = 16;
  localparam int WT = 32;

  logic          clk, rst_n, go;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready, src_rewind;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, busy, job_done, job_fail;
  logic [31:0]   cycle_count;
  logic [1:0]    sys_gen_left_op, sys_gen_right_op;
  logic          sys_start, sys_start_right, sys_done, sys_success, sys_fail;
  logic          sys_wr_en, sys_rd_en;
  logic [AW-1:0] sys_wr_addr, sys_rd_addr;
  logic [DW-1:0] sys_wr_data;
  logic [DW-1:0] sys_rd_data = '0;

  systemizer_host_ctrl dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .src_rewind(src_rewind),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .job_done(job_done), .job_fail(job_fail), .cycle_count(cycle_count),
    .sys_gen_left_op(sys_gen_left_op), .sys_gen_right_op(sys_gen_right_op),
    .sys_start(sys_start), .sys_start_right(sys_start_right),
    .sys_done(sys_done), .sys_success(sys_success), .sys_fail(sys_fail),
    .sys_wr_en(sys_wr_en), .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data),
    .sys_rd_en(sys_rd_en), .sys_rd_addr(sys_rd_addr), .sys_rd_data(sys_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Source model: word = {rewind tag, index}; the tag advances on every rewind.
  int         vmode = 0;
  logic [5:0] sp  = '0;
  logic [3:0] tag = '0;
  logic       tog = 1'b0;
  always @(posedge clk) begin
    tog <= ~tog;
    if (src_rewind) begin
      sp  <= '0;
      tag <= tag + 4'd1;
    end else if (in_valid && in_ready) begin
      sp <= sp + 6'd1;
    end
  end
  assign in_valid = (vmode == 0) ? 1'b1 : tog;
  assign in_data  = {tag, 7'd0, sp[4:0]};

  // Sink: always ready or ready ~30% of cycles.
  int   rmode = 0;
  logic rdy_rnd = 1'b0;
  always @(posedge clk) rdy_rnd <= ($urandom_range(0, 99) < 30);
  assign out_ready = (rmode == 0) ? 1'b1 : rdy_rnd;

  // Systemizer model: memory plus a status pulse a fixed delay after each start.
  // oc: 0 done, 1 fail, 2 success then done, 3 success then fail,
  //     4 fail+done+success together, 5 done+success together.
  logic [DW-1:0] mem [WT];
  logic          armed = 1'b0, rphase = 1'b0, preset = 1'b0, hit;
  int            tmr = 0, dly_l = 1, dly_r = 1, oc = 0;
  always @(posedge clk) begin
    if (preset) for (int i = 0; i < WT; i++) mem[i] <= 16'hC000 | 16'(i);
    else if (sys_wr_en) mem[sys_wr_addr] <= sys_wr_data;
    if (sys_rd_en) sys_rd_data <= mem[sys_rd_addr];
    if (sys_start) begin
      armed <= 1'b1; rphase <= 1'b0; tmr <= 1;
    end else if (sys_start_right) begin
      armed <= 1'b1; rphase <= 1'b1; tmr <= 1;
    end else if (armed) begin
      if (hit) armed <= 1'b0;
      else     tmr <= tmr + 1;
    end
  end
  assign hit         = armed && (tmr == (rphase ? dly_r : dly_l));
  assign sys_fail    = (hit && !rphase && (oc == 1 || oc == 4)) || (hit && rphase && oc == 3);
  assign sys_done    = (hit && !rphase && (oc == 0 || oc == 4 || oc == 5)) ||
                       (hit && rphase && oc == 2);
  assign sys_success = hit && !rphase && (oc >= 2);

  // Monitor, sampled on the falling edge.
  logic [AW-1:0] wr_a [$];
  logic [DW-1:0] wr_d [$];
  logic [DW-1:0] pop_q [$];
  int n_start = 0, n_startr = 0, n_rew = 0, n_ovalid = 0, n_done = 0, n_fail = 0;
  always @(negedge clk) begin
    if (sys_wr_en) begin
      wr_a.push_back(sys_wr_addr);
      wr_d.push_back(sys_wr_data);
    end
    if (out_valid && out_ready) pop_q.push_back(out_data);
    if (sys_start)       n_start++;
    if (sys_start_right) n_startr++;
    if (src_rewind)      n_rew++;
    if (out_valid)       n_ovalid++;
    if (job_done)        n_done++;
    if (job_fail)        n_fail++;
  end

  logic any_out;
  assign any_out = |{in_ready, src_rewind, out_data, out_valid, busy, job_done, job_fail,
                     cycle_count, sys_start, sys_start_right, sys_wr_en, sys_wr_addr,
                     sys_wr_data, sys_rd_en, sys_rd_addr};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lop, rop, oc, dl, dr, vm, rm, go2;
    int exp_nwr, exp_sr, exp_rew, exp_out, exp_done, exp_fail, exp_cc;
  } vec_t;

  task automatic run_job(input int id, input vec_t v);
    logic [AW-1:0] ea [$];
    logic [DW-1:0] ed [$];
    logic [DW-1:0] em [WT];
    logic [3:0]    tl, tr;
    int b_wr, b_pop, b_st, b_sr, b_rew, b_ov, b_dn, b_fl, lo, hi, bad;
    logic ok, busy_t, busy_n;
    logic [31:0] cc;
    string p;
    p = $sformatf("job%0d_", id);
    sys_gen_left_op = 2'(v.lop); sys_gen_right_op = 2'(v.rop);
    oc = v.oc; dly_l = v.dl; dly_r = v.dr; vmode = v.vm; rmode = v.rm;
    preset = 1'b1;
    @(posedge clk); #1;
    preset = 1'b0;
    tl = tag + 4'd1; tr = tag + 4'd2;
    b_wr = wr_a.size(); b_pop = pop_q.size(); b_st = n_start; b_sr = n_startr;
    b_rew = n_rew; b_ov = n_ovalid; b_dn = n_done; b_fl = n_fail;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    if (v.go2 != 0) begin
      for (int c = 0; c < 200 && wr_a.size() < b_wr + 5; c++) @(negedge clk);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (job_done || job_fail) begin
        ok = 1'b1;
        break;
      end
    end
    chk({p, "finished"}, longint'(ok), 1);
    if (!ok) return;
    busy_t = busy;
    @(negedge clk);
    busy_n = busy;
    cc = cycle_count;
    @(negedge clk);
    // Expected write sequence and final memory image.
    for (int i = 0; i < WT; i++) em[i] = 16'hC000 | 16'(i);
    hi = (v.lop == 1) ? 16 : 32;
    for (int a = 0; a < hi; a++) begin
      ea.push_back(AW'(a)); ed.push_back({tl, 7'd0, 5'(a)});
    end
    if (v.oc == 2 || v.oc == 3) begin
      lo = (v.rop == 2) ? 16 : 0;
      hi = (v.rop == 1) ? 16 : 32;
      for (int a = lo; a < hi; a++) begin
        ea.push_back(AW'(a)); ed.push_back({tr, 7'd0, 5'(a)});
      end
    end
    for (int i = 0; i < ea.size(); i++) em[ea[i]] = ed[i];
    bad = 0;
    for (int i = 0; i < ea.size(); i++)
      if (b_wr + i >= wr_a.size() || wr_a[b_wr + i] !== ea[i] || wr_d[b_wr + i] !== ed[i])
        bad++;
    chk({p, "n_writes"}, wr_a.size() - b_wr, v.exp_nwr);
    chk({p, "write_seq_errs"}, bad, 0);
    chk({p, "n_start"}, n_start - b_st, 1);
    chk({p, "n_start_right"}, n_startr - b_sr, v.exp_sr);
    chk({p, "n_rewind"}, n_rew - b_rew, v.exp_rew);
    chk({p, "n_out_words"}, pop_q.size() - b_pop, v.exp_out);
    chk({p, "job_done_pulses"}, n_done - b_dn, v.exp_done);
    chk({p, "job_fail_pulses"}, n_fail - b_fl, v.exp_fail);
    chk({p, "busy_then_idle"}, longint'({busy_t, busy_n}), 2);
    if (v.exp_out > 0) begin
      bad = 0;
      for (int i = 0; i < v.exp_out; i++)
        if (b_pop + i >= pop_q.size() || pop_q[b_pop + i] !== em[i]) bad++;
      chk({p, "out_data_errs"}, bad, 0);
    end else begin
      chk({p, "out_valid_cycles"}, n_ovalid - b_ov, 0);
    end
    if (v.exp_cc >= 0) chk({p, "cycle_count"}, longint'(cc), v.exp_cc);
  endtask

  vec_t vecs [11];
  int   b;

  initial begin
    //        lop rop oc  dl  dr vm rm g2  nwr sr rew out dn fl  cc
    vecs[0]  = '{0, 0, 0, 100, 0, 0, 0, 0, 32, 0, 1, 32, 1, 0, 100};
    vecs[1]  = '{1, 0, 0, 10,  0, 1, 0, 1, 16, 0, 1, 32, 1, 0, 10};
    vecs[2]  = '{3, 0, 1, 5,   0, 0, 0, 0, 32, 0, 1, 0,  0, 1, 5};
    vecs[3]  = '{0, 2, 2, 20, 30, 0, 0, 0, 48, 1, 2, 32, 1, 0, 85};
    vecs[4]  = '{0, 2, 2, 20, 30, 0, 1, 0, 48, 1, 2, 32, 1, 0, 85};
    vecs[5]  = '{1, 1, 3, 8,  12, 1, 0, 0, 32, 1, 2, 0,  0, 1, -1};
    vecs[6]  = '{0, 0, 4, 7,   0, 0, 0, 0, 32, 0, 1, 0,  0, 1, 7};
    vecs[7]  = '{0, 0, 5, 9,   0, 0, 1, 0, 32, 0, 1, 32, 1, 0, 9};
    vecs[8]  = '{3, 3, 2, 4,   6, 0, 1, 0, 64, 1, 2, 32, 1, 0, 45};
    vecs[9]  = '{0, 1, 2, 6,   5, 0, 0, 0, 48, 1, 2, 32, 1, 0, 30};
    vecs[10] = '{0, 0, 0, 15,  0, 0, 0, 0, 32, 0, 1, 32, 1, 0, 15};

    rst_n = 1'b0; go = 1'b0;
    sys_gen_left_op = 2'b00; sys_gen_right_op = 2'b00;
    #12;
    chk("reset_outputs_or", longint'(any_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", longint'(busy), 0);

    for (int i = 0; i < 10; i++) run_job(i, vecs[i]);

    // Reset in the middle of the left load, after 10 words have been written.
    sys_gen_left_op = 2'b00; oc = 0; dly_l = 50; vmode = 0; rmode = 0;
    b = wr_a.size();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int c = 0; c < 200 && wr_a.size() < b + 10; c++) @(negedge clk);
    chk("midload_writes", wr_a.size() - b, 10);
    chk("midload_busy", longint'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midload_reset_outputs_or", longint'(any_out), 0);
    chk("midload_reset_cycle_count", longint'(cycle_count), 0);
    @(negedge clk);
    chk("reset_held_outputs_or", longint'(any_out), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(10, vecs[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
